// File: rtl/property_sweep_pkg.sv
// Shared types and constants for the property sweep checker.
// Holds the FSM state encoding and the bit positions within the props vector.
package property_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS = 16;
    localparam int NUM_PROPS   = 9;

    localparam int PROP_ALWAYS_TRUE     = 0;
    localparam int PROP_ALWAYS_FALSE    = 1;
    localparam int PROP_DOUBLE_NEGATION = 2;
    localparam int PROP_AND_IDENTITY    = 3;
    localparam int PROP_OR_IDENTITY     = 4;
    localparam int PROP_COMMUTATIVITY   = 5;
    localparam int PROP_ASSOCIATIVITY   = 6;
    localparam int PROP_DE_MORGAN_NAND  = 7;
    localparam int PROP_DE_MORGAN_NOR   = 8;

endpackage

// File: rtl/property_sweep_if.sv
// Bundle between the sweep checker and its environment: run handshake,
// results, stimulus to the checked block and the property outputs coming back.
interface property_sweep_if;
    import property_sweep_pkg::*;

    logic                 start;
    logic                 a;
    logic                 b;
    logic                 c;
    logic                 d;
    logic [NUM_PROPS-1:0] props;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [4:0]           fail_count;
    logic [3:0]           first_fail_vec;
    logic [NUM_PROPS-1:0] first_fail_mask;

    // The checker itself
    modport slave (
        input  start,
        input  props,
        output a,
        output b,
        output c,
        output d,
        output busy,
        output done,
        output pass,
        output fail_count,
        output first_fail_vec,
        output first_fail_mask
    );

    // Whoever requests runs and hosts the checked block
    modport master (
        output start,
        output props,
        input  a,
        input  b,
        input  c,
        input  d,
        input  busy,
        input  done,
        input  pass,
        input  fail_count,
        input  first_fail_vec,
        input  first_fail_mask
    );

endinterface

// File: rtl/property_expect.sv
// Expected property outputs for one stimulus vector v = {a, b, c, d}.
// The identity-style properties echo a; the equivalences are constant true.
module property_expect
    import property_sweep_pkg::*;
(
    input  logic [3:0]           v,
    output logic [NUM_PROPS-1:0] expected
);

    logic a;
    logic unused_bcd;

    assign a          = v[3];
    assign unused_bcd = ^v[2:0];

    always_comb begin
        expected                       = '0;
        expected[PROP_ALWAYS_TRUE]     = 1'b1;
        expected[PROP_ALWAYS_FALSE]    = 1'b0;
        expected[PROP_DOUBLE_NEGATION] = a;
        expected[PROP_AND_IDENTITY]    = a;
        expected[PROP_OR_IDENTITY]     = a;
        expected[PROP_COMMUTATIVITY]   = 1'b1;
        expected[PROP_ASSOCIATIVITY]   = 1'b1;
        expected[PROP_DE_MORGAN_NAND]  = 1'b1;
        expected[PROP_DE_MORGAN_NOR]   = 1'b1;
    end

endmodule

// File: rtl/property_sweep_checker.sv
// Sweeps a..d through all 16 patterns, lets each settle, and compares props
// against the expected table; reports pass, failure count and first failure.
//
// state  | meaning
// IDLE   | waiting for start, stimulus held at 0
// SETTLE | vector applied, counting down the settle time
// CHECK  | props sampled and compared at the end of this cycle
// DONE   | results valid and held until the next start
module property_sweep_checker
    import property_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    property_sweep_if.slave   bus
);

    localparam int              CW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      LAST_VEC    = 4'(NUM_VECTORS - 1);

    state_t               state;
    logic [3:0]           vec;
    logic [CW-1:0]        cnt;
    logic [3:0]           stim;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [4:0]           fail_count_q;
    logic [3:0]           first_fail_vec_q;
    logic [NUM_PROPS-1:0] first_fail_mask_q;

    logic [NUM_PROPS-1:0] expected;
    logic [NUM_PROPS-1:0] mask;
    logic                 mismatch;

    property_expect u_expect (
        .v        (vec),
        .expected (expected)
    );

    assign mask     = bus.props ^ expected;
    assign mismatch = |mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            vec               <= '0;
            cnt               <= '0;
            stim              <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            fail_count_q      <= '0;
            first_fail_vec_q  <= '0;
            first_fail_mask_q <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state             <= ST_SETTLE;
                        vec               <= '0;
                        cnt               <= SETTLE_LOAD;
                        stim              <= '0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        fail_count_q      <= '0;
                        first_fail_vec_q  <= '0;
                        first_fail_mask_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        fail_count_q <= fail_count_q + 5'd1;
                        if (fail_count_q == '0) begin
                            first_fail_vec_q  <= vec;
                            first_fail_mask_q <= mask;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        // pass must reflect this final vector too, not just the count so far
                        state  <= ST_DONE;
                        stim   <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (fail_count_q == '0) && !mismatch;
                    end else begin
                        state <= ST_SETTLE;
                        vec   <= vec + 4'd1;
                        stim  <= vec + 4'd1;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a               = stim[3];
    assign bus.b               = stim[2];
    assign bus.c               = stim[1];
    assign bus.d               = stim[0];
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.fail_count      = fail_count_q;
    assign bus.first_fail_vec  = first_fail_vec_q;
    assign bus.first_fail_mask = first_fail_mask_q;

endmodule

// File: doc/property_sweep_checker.md
# property_sweep_checker

Self-checking harness stage wrapped around the logic-properties block. It drives the four inputs `a`, `b`, `c`, `d` exhaustively through all 16 patterns. After a programmable settle time it samples the nine property outputs and compares them against their expected values. It then reports pass/fail, the failure count and the first failing vector through a start/done handshake.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling.
  - Legal range 1..255.
  - Settle counter width is `$clog2(SETTLE_CYCLES+1)`.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: run request. Sampled only in IDLE or DONE.
- `a`, `b`, `c`, `d`  out  1 each: stimulus to the checked block.
- `props`  in  9: property outputs from the checked block. Bit order:
  - [0] always_true, [1] always_false, [2] double_negation
  - [3] and_identity, [4] or_identity
  - [5] commutativity, [6] associativity
  - [7] de_morgan_nand, [8] de_morgan_nor
- `busy`  out  1: high in SETTLE and CHECK.
- `done`  out  1: high in DONE; held until the next accepted start or reset.
- `pass`  out  1: valid while `done`. 1 when `fail_count` == 0.
- `fail_count`  out  5: number of vectors with any mismatch, 0..16.
- `first_fail_vec`  out  4: vector index of the first mismatch.
- `first_fail_mask`  out  9: `props` XOR expected at the first mismatch.

## Operation

- Vector index `v` runs 0..15. Mapping: `a`=v[3], `b`=v[2], `c`=v[1], `d`=v[0].
- Expected props for vector `v`:
  - [0]=1, [1]=0.
  - [2], [3], [4] = `a`.
  - [5]..[8] = 1.
- Mismatch mask = `props` XOR expected. A vector fails when the mask is non-zero.
- States: IDLE, SETTLE, CHECK, DONE.
  - IDLE: `start`=1 → SETTLE. Load `v`=0 and settle count = SETTLE_CYCLES-1. Clear `fail_count`, `first_fail_vec`, `first_fail_mask` and `pass`.
  - SETTLE: count==0 → CHECK; otherwise decrement.
  - CHECK: sample `props` and evaluate the mismatch mask.
    - On a mismatch, increment `fail_count`.
    - If `fail_count` was 0 before this increment, also capture `v` and the mask.
    - If `v`==15 → DONE and register `pass` = (final `fail_count` == 0).
    - Otherwise increment `v`, reload the count, → SETTLE.
  - DONE: `start`=1 → same action as from IDLE (restart and clear results).
- `start` in SETTLE or CHECK is ignored.
- `a`..`d` are 0 in IDLE and DONE. In SETTLE and CHECK they carry `v` and are registered; they change only on the SETTLE entry edge.
- Results (`fail_count`, `first_fail_*`, `pass`) hold their values in DONE until the next accepted start.

## Timing

- Reset value of every output is 0. State returns to IDLE.
- Reset mid-run aborts immediately. No partial results are retained.
- Let start be accepted at edge t:
  - Vector 0 appears on `a`..`d` after edge t.
  - Each vector lasts SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, then 1 in CHECK.
  - `props` is sampled at the edge ending the CHECK cycle.
  - `done` rises after edge t + 16·(SETTLE_CYCLES+1). With SETTLE_CYCLES=1 that is 32 edges after the start edge.
- `busy` and `done` are mutually exclusive and are never both low outside IDLE.
- If `start` and `rst` are high together, `rst` wins.

## Structure

- Package `property_sweep_pkg` contains:
  - the state enum;
  - `NUM_VECTORS`=16 and `NUM_PROPS`=9;
  - named bit-index constants for `props`.
- Sub-module `property_expect`: purely combinational.
  - Input: 4-bit `v`.
  - Output: 9-bit expected vector.
  - Keeps the expected-value table separate from the sequencing.
- The top level holds the FSM, the vector counter, the settle counter and the result registers.

## Test plan

- Ideal behavioural model of the checked block, SETTLE_CYCLES=1, pulse start:
  - `busy` asserts after the start edge.
  - `done` rises 32 edges after the start edge.
  - `pass`=1, `fail_count`=0.
- Model with `props[1]` stuck at 1: `fail_count`=16, `first_fail_vec`=0, `first_fail_mask`=9'h002, `pass`=0.
- Model with `props[2]` inverted only when `a`=1: `fail_count`=8, `first_fail_vec`=8, `first_fail_mask`=9'h004.
- Assert `rst` while `v`=5: all outputs 0 on the next cycle. A new start then completes a full 16-vector run with a clean result.
- Pulse `start` during SETTLE: no effect, completion time unchanged. Then pulse `start` in DONE: results clear and a new run begins.
- SETTLE_CYCLES=3: each vector is held 4 cycles and `done` rises 64 edges after the start edge. A model that only updates `props` on its second cycle after the vector changes still passes.
